// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display constants for the hex scanner and decoder wrapper
package display_pkg;
  localparam int DEF_SLOT_CYCLES  = 50000;
  localparam int DEF_GUARD_CYCLES = 2;
  localparam int MAX_DIGITS       = 32;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
endpackage

// File: rtl/hex_display_scanner_slot_timer.sv
// rtl/hex_display_scanner_slot_timer.sv - per-digit slot counter with boundary and guard-end strobes
module slot_timer
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic slot_tick,
  output logic guard_end
);
  localparam int CW = $clog2(SLOT_CYCLES);

  logic [CW-1:0] cnt;

  // Strobes mark the edge that takes the counter to 0 (boundary) or to GUARD_CYCLES,
  // so the registered anodes are low exactly while the counter reads >= GUARD_CYCLES.
  assign slot_tick = (cnt == CW'(SLOT_CYCLES - 1));
  assign guard_end = (cnt == CW'(GUARD_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (slot_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed hex digit scanner with blanking and guard interval
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_en,
  output logic [3:0]              nibble,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] OFF = ANODE_OFF[NUM_DIGITS-1:0];

  logic                  slot_tick;
  logic                  guard_end;
  logic [W-1:0]          shadow;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic                  lz;
  logic                  lz_next;
  logic                  blanked;
  logic [NUM_DIGITS-1:0] anode_on;

  slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .slot_tick(slot_tick),
    .guard_end(guard_end)
  );

  // lz is captured at the boundary from the same shadow snapshot as the nibble,
  // so a mid-slot load can never change what the current slot shows.
  always_comb begin
    idx_next = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    lz_next  = ((shadow >> (4 * idx_next)) == '0);
    blanked  = blank_en && lz && (idx != '0);
    anode_on = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      idx        <= '0;
      lz         <= 1'b0;
      nibble     <= '0;
      anode_n    <= OFF;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow <= value;
      end
      frame_done <= slot_tick && (idx == IW'(NUM_DIGITS - 1));
      if (slot_tick) begin
        idx     <= idx_next;
        nibble  <= shadow[4*idx_next +: 4];
        anode_n <= OFF;
        lz      <= lz_next;
      end else if (guard_end && !blanked) begin
        anode_n <= anode_on;
      end
    end
  end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - self-checking bench for hex_display_scanner
module tb_hex_display_scanner;
  localparam int N  = 4;
  localparam int SC = 8;
  localparam int GC = 2;
  localparam int HMAX = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blank_en = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  anode_n;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int k = 0;
  logic [15:0] shv [HMAX];
  logic        blv [HMAX];
  logic [3:0]  prev_anode = 4'hF;
  logic [3:0]  prev_nib = 4'h0;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS  (N),
    .SLOT_CYCLES (SC),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .blank_en  (blank_en),
    .nibble    (nibble),
    .anode_n   (anode_n),
    .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  // Reference: slot s = k/SC shows digit s%N of the shadow value held just before
  // the edge that opened the slot; slot 0 after reset shows the reset shadow (0).
  task automatic check_cycle();
    int s, c, d;
    logic [15:0] v;
    logic        bl;
    logic [3:0]  exp_an;
    s = k / SC;
    c = k % SC;
    d = s % N;
    v = (s == 0) ? 16'h0 : shv[SC*s-1];
    bl = 1'b0;
    if (c >= GC) bl = (d > 0) && blv[SC*s+GC] && ((v >> (4*d)) == 16'h0);
    exp_an = (c < GC || bl) ? 4'hF : ~(4'b0001 << d);
    chk("nibble", 32'(nibble), 32'((v >> (4*d)) & 16'hF));
    chk("anode_n", 32'(anode_n), 32'(exp_an));
    chk("frame_done", 32'(frame_done), 32'(k > 0 && (k % (SC*N)) == 0));
    chk("one_hot_anode", 32'($countones(~anode_n) <= 1), 32'd1);
    if (prev_anode != 4'hF && anode_n != 4'hF) chk("nibble_stable", 32'(nibble), 32'(prev_nib));
    prev_anode = anode_n;
    prev_nib = nibble;
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic be);
    if (k + 1 >= HMAX) begin
      failures++;
      $display("FAIL history_bound k=%0d actual=%0d required<%0d", k, k + 1, HMAX);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
    end
    load = ld;
    value = v;
    blank_en = be;
    shv[k+1] = ld ? v : shv[k];
    blv[k+1] = be;
    @(posedge clk);
    k++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    load = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_anode_async", 32'(anode_n), 32'hF);
    @(negedge clk);
    @(negedge clk);
    chk("reset_nibble", 32'(nibble), 32'h0);
    chk("reset_frame_done", 32'(frame_done), 32'h0);
    reset = 1'b0;
    k = 0;
    shv[0] = 16'h0;
    prev_anode = 4'hF;
    check_cycle();
  endtask

  typedef struct {
    logic [15:0] v;
    logic        be;
    logic [15:0] nibs;
    logic [15:0] ans;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lowcnt;
    vecs[0] = '{16'h1A2F, 1'b0, 16'h1A2F, 16'h7BDE};
    vecs[1] = '{16'h0030, 1'b1, 16'h0030, 16'hFFDE};
    vecs[2] = '{16'h0000, 1'b1, 16'h0000, 16'hFFFE};
    vecs[3] = '{16'h0500, 1'b1, 16'h0500, 16'hFBDE};
    vecs[4] = '{16'h1A2F, 1'b1, 16'h1A2F, 16'h7BDE};

    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      do_reset();
      step(1'b1, vecs[i].v, vecs[i].be);
      while (k < SC*N) step(1'b0, 16'h0, vecs[i].be);
      for (int d = 0; d < N; d++) begin
        lowcnt = 0;
        for (int c = 0; c < SC; c++) begin
          if (anode_n[d] == 1'b0) lowcnt++;
          if (c == 4) begin
            chk("tbl_nibble", 32'(nibble), 32'(vecs[i].nibs[4*d +: 4]));
            chk("tbl_anode", 32'(anode_n), 32'(vecs[i].ans[4*d +: 4]));
          end
          step(1'b0, 16'h0, vecs[i].be);
        end
        chk("tbl_low_cycles", 32'(lowcnt), (vecs[i].ans[4*d +: 4] == 4'hF) ? 32'd0 : 32'(SC - GC));
      end
    end

    // load coinciding with a boundary edge
    do_reset();
    step(1'b1, 16'hABCD, 1'b0);
    while (k < SC*N - 1) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("bnd_load_old_nibble", 32'(nibble), 32'hD);
    chk("bnd_load_old_anode", 32'(anode_n), 32'hE);
    while (k < SC*N + SC) step(1'b0, 16'h0, 1'b0);
    chk("bnd_load_new_nibble", 32'(nibble), 32'h3);

    // reset mid-slot while an anode is low
    do_reset();
    step(1'b1, 16'h00F7, 1'b0);
    while (k < SC + 5) step(1'b0, 16'h0, 1'b0);
    chk("pre_reset_anode", 32'(anode_n), 32'hD);
    chk("pre_reset_nibble", 32'(nibble), 32'hF);
    #2;
    reset = 1'b1;
    #1;
    chk("midslot_reset_anode", 32'(anode_n), 32'hF);
    chk("midslot_reset_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    chk("midslot_reset_nibble", 32'(nibble), 32'h0);
    reset = 1'b0;
    k = 0;
    shv[0] = 16'h0;
    prev_anode = 4'hF;
    check_cycle();
    while (k < GC + 1) step(1'b0, 16'h0, 1'b0);
    chk("post_reset_anode", 32'(anode_n), 32'hE);
    chk("post_reset_nibble", 32'(nibble), 32'h0);

    // randomized traffic against the reference
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 7) == 0, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
